mdu_iter: RTL
=============

// Module: mdu_iter
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit for the EX stage: MULT/MULTU, MADD/MADDU, MSUB/MSUBU, DIV/DIVU.
//  EX issues one op with start_i and stalls while busy_o is high. It consumes done_o/result_o and writes {HI,LO}.
//  Replaces the in-EX madd/msub two-pass counter and the separate divider handshake.
//  Adds configurable width, multiply latency, annul (flush) and divide-by-zero flagging.
// PARAMETERS
//  W        32  operand width; result is 2*W ({hi,lo})
//  MUL_LAT  2   cycles in MUL state (>=1); product register pipeline depth
// PORTS
//  clk           in   1    clock, rising edge
//  rst           in   1    reset, synchronous, active-high
//  start_i       in   1    issue request; sampled only in IDLE
//  op_i          in   3    mdu_op_t opcode, sampled with start_i
//  opa_i         in   W    operand A / dividend
//  opb_i         in   W    operand B / divisor
//  hilo_i        in   2W   forwarded {HI,LO} for MADD/MSUB; sampled with start_i
//  annul_i       in   1    flush: abort current op
//  busy_o        out  1    high in every state except IDLE
//  done_o        out  1    single-cycle completion pulse
//  result_o      out  2W   {hi,lo}; held from done until next accepted start
//  div_by_zero_o out  1    valid with done_o; set for DIV/DIVU with opb==0
// BEHAVIOUR
//  Reset: state=IDLE; busy_o, done_o, div_by_zero_o = 0; result_o = 0; counters = 0.
//  rst mid-operation aborts with no done_o.
//  FSM states: IDLE, MUL, ACC, DIV, DONE.
//  - IDLE + start_i & !annul_i: latch op, opa, opb, hilo.
//    DIV* with opb==0 -> DONE. DIV* -> DIV. Otherwise -> MUL.
//  - MUL: full 2W product through MUL_LAT registers.
//    Signed ops use two's-complement operands; U ops zero-extend.
//    After MUL_LAT cycles: MULT* -> DONE; MADD*/MSUB* -> ACC.
//  - ACC: one cycle. result = hilo + prod (MADD*) or hilo - prod (MSUB*), mod 2^(2W), no overflow trap.
//  - DIV: restoring radix-2 on magnitudes, W cycles.
//    Sign fix on exit: quotient negated if sign(a)!=sign(b) (DIV only); remainder takes sign of a.
//    result = {rem, quo}.
//  - DONE: done_o=1 for exactly this cycle -> IDLE.
//  Latency, start edge to done_o cycle:
//    MULT* MUL_LAT+1; MADD*/MSUB* MUL_LAT+2; DIV* W+1; divide-by-zero 1 (result 0, div_by_zero_o=1).
//  start_i outside IDLE is ignored, with no queueing.
//  annul_i in any non-IDLE state -> IDLE next edge: no done_o, result_o unchanged, busy_o low next cycle.
//  annul_i with start_i in IDLE: annul wins, nothing accepted.
//  div_by_zero_o is cleared at the next accepted start.
//  DIV of most-negative by -1: quotient wraps to most-negative, remainder 0.
// STRUCTURE
//  mdu_pkg holds mdu_op_t (MULT=0, MULTU=1, MADD=2, MADDU=3, MSUB=4, MSUBU=5, DIV=6, DIVU=7), the state enum and latency constants.
//  Sub-module mdu_div_core: W-cycle unsigned restoring divider with start/done handshake.
//  Sign handling and the FSM stay in mdu_iter.
// TESTING (W=32, MUL_LAT=2)
//  1. MULT -3*5 -> done at +3, result 64'hFFFFFFFF_FFFFFFF1.
//     MULTU 32'hFFFFFFFF^2 -> 64'hFFFFFFFE_00000001.
//  2. MADD hilo=64'h10, 4*-2 -> done at +4, result 64'h8.
//     MSUBU hilo=0, 1*1 -> 64'hFFFFFFFF_FFFFFFFF.
//  3. DIV -7/2 -> done at +33, hi=32'hFFFFFFFF, lo=32'hFFFFFFFD.
//     DIVU 7/2 -> hi=1, lo=3.
//  4. DIVU 7/0 -> done at +1, div_by_zero_o=1, result 0.
//     Next MULT 1*1 -> div_by_zero_o=0.
//  5. annul_i at cycle +10 of DIV -> no done_o, busy_o=0 next cycle, result_o unchanged.
//     Immediate new start accepted.
//  6. start_i pulsed while busy -> ignored, only one done_o.
//     rst asserted mid-MUL -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared opcode/state types and latency helpers for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MADD  = 3'd2,
    OP_MADDU = 3'd3,
    OP_MSUB  = 3'd4,
    OP_MSUBU = 3'd5,
    OP_DIV   = 3'd6,
    OP_DIVU  = 3'd7
  } mdu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_ACC  = 3'd2,
    ST_DIV  = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_t;

  localparam int unsigned DIV0_LAT = 1;

  // Start-to-done latencies in cycles for a given configuration.
  function automatic int unsigned mult_lat(input int unsigned mul_lat);
    return mul_lat + 1;
  endfunction

  function automatic int unsigned macc_lat(input int unsigned mul_lat);
    return mul_lat + 2;
  endfunction

  function automatic int unsigned div_lat(input int unsigned w);
    return w + 1;
  endfunction

  // Even opcodes are the signed variants.
  function automatic logic op_is_signed(input mdu_op_t op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input mdu_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Unsigned restoring radix-2 divider: W iterations, the first taken on the start edge.
module mdu_div_core
  import mdu_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic         i_abort,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic         o_done,
  output logic [W-1:0] o_quo,
  output logic [W-1:0] o_rem
);

  localparam int unsigned CNT_W = $clog2(W);

  logic [W-1:0]     r_quo;
  logic [W-1:0]     r_rem;
  logic [W-1:0]     r_divisor;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic             r_done;

  logic [W-1:0] w_src_q;
  logic [W-1:0] w_src_r;
  logic [W-1:0] w_dvs;
  logic [W:0]   w_sh;
  logic [W:0]   w_diff;
  logic [W-1:0] w_q_nx;
  logic [W-1:0] w_r_nx;

  // One shift-subtract step; on start it works straight from the inputs.
  always_comb begin
    w_src_q = i_start ? i_dividend : r_quo;
    w_src_r = i_start ? '0 : r_rem;
    w_dvs   = i_start ? i_divisor : r_divisor;
    w_sh    = {w_src_r, w_src_q[W-1]};
    w_diff  = w_sh - {1'b0, w_dvs};
    if (w_diff[W]) begin
      w_r_nx = w_sh[W-1:0];
      w_q_nx = {w_src_q[W-2:0], 1'b0};
    end else begin
      w_r_nx = w_diff[W-1:0];
      w_q_nx = {w_src_q[W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_quo     <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      r_run     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_abort) begin
        r_run <= 1'b0;
        r_cnt <= '0;
      end else if (i_start || r_run) begin
        r_quo <= w_q_nx;
        r_rem <= w_r_nx;
        if (i_start) begin
          r_divisor <= i_divisor;
          r_run     <= 1'b1;
          r_cnt     <= CNT_W'(1);
        end else if (r_cnt == CNT_W'(W - 1)) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_quo  = r_quo;
  assign o_rem  = r_rem;

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle multiply / multiply-accumulate / divide unit for the EX stage.
// Result is {hi,lo}; divides report {rem,quo}, with divide-by-zero flagged.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned W       = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  mdu_op_t        op_i,
  input  logic [W-1:0]   opa_i,
  input  logic [W-1:0]   opb_i,
  input  logic [2*W-1:0] hilo_i,
  input  logic           annul_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [2*W-1:0] result_o,
  output logic           div_by_zero_o
);

  localparam int unsigned W2    = 2 * W;
  localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  mdu_state_t       r_state;
  mdu_op_t          r_op;
  logic [W2-1:0]    r_hilo;
  logic [W2-1:0]    r_result;
  logic             r_a_neg;
  logic             r_b_neg;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [CNT_W-1:0] r_cnt;
  logic [W2-1:0]    r_pipe [MUL_LAT];

  logic          w_accept;
  logic          w_signed;
  logic          w_is_div;
  logic          w_b_zero;
  logic          w_a_neg;
  logic          w_b_neg;
  logic          w_mul_last;
  logic [W2-1:0] w_a_ext;
  logic [W2-1:0] w_b_ext;
  logic [W2-1:0] w_prod;
  logic [W2-1:0] w_prod_out;
  logic [W-1:0]  w_a_mag;
  logic [W-1:0]  w_b_mag;
  logic          w_core_start;
  logic          w_core_done;
  logic [W-1:0]  w_core_quo;
  logic [W-1:0]  w_core_rem;
  logic [W-1:0]  w_quo_fix;
  logic [W-1:0]  w_rem_fix;

  assign w_accept   = (r_state == ST_IDLE) && start_i && !annul_i;
  assign w_signed   = op_is_signed(op_i);
  assign w_is_div   = op_is_div(op_i);
  assign w_b_zero   = (opb_i == '0);
  assign w_a_neg    = w_signed && opa_i[W-1];
  assign w_b_neg    = w_signed && opb_i[W-1];
  assign w_mul_last = (r_cnt == CNT_W'(MUL_LAT - 1));

  // Full-width product: sign- or zero-extend, keep the low 2W bits.
  assign w_a_ext    = w_signed ? {{W{opa_i[W-1]}}, opa_i} : {{W{1'b0}}, opa_i};
  assign w_b_ext    = w_signed ? {{W{opb_i[W-1]}}, opb_i} : {{W{1'b0}}, opb_i};
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_prod_out = r_pipe[MUL_LAT-1];

  // Divider works on magnitudes; the most-negative value maps to itself, which is its correct unsigned magnitude.
  assign w_a_mag      = w_a_neg ? (~opa_i + W'(1)) : opa_i;
  assign w_b_mag      = w_b_neg ? (~opb_i + W'(1)) : opb_i;
  assign w_core_start = w_accept && w_is_div && !w_b_zero;
  assign w_quo_fix    = (r_a_neg ^ r_b_neg) ? (~w_core_quo + W'(1)) : w_core_quo;
  assign w_rem_fix    = r_a_neg ? (~w_core_rem + W'(1)) : w_core_rem;

  mdu_div_core #(.W(W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_core_start),
    .i_abort    (annul_i),
    .i_dividend (w_a_mag),
    .i_divisor  (w_b_mag),
    .o_done     (w_core_done),
    .o_quo      (w_core_quo),
    .o_rem      (w_core_rem)
  );

  // Product pipeline; frozen on the last MUL cycle so ACC sees the product.
  always_ff @(posedge clk) begin
    if (w_accept || (r_state == ST_MUL && !w_mul_last)) begin
      r_pipe[0] <= w_prod;
      for (int unsigned k = 1; k < MUL_LAT; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_MULT;
      r_hilo   <= '0;
      r_result <= '0;
      r_a_neg  <= 1'b0;
      r_b_neg  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      if (annul_i && r_state != ST_IDLE) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              r_op    <= op_i;
              r_hilo  <= hilo_i;
              r_a_neg <= w_a_neg;
              r_b_neg <= w_b_neg;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_dbz   <= 1'b0;
              if (w_is_div && w_b_zero) begin
                r_state  <= ST_DONE;
                r_result <= '0;
                r_dbz    <= 1'b1;
                r_done   <= 1'b1;
              end else if (w_is_div) begin
                r_state <= ST_DIV;
              end else begin
                r_state <= ST_MUL;
              end
            end
          end
          ST_MUL: begin
            if (w_mul_last) begin
              r_cnt <= '0;
              if (r_op == OP_MULT || r_op == OP_MULTU) begin
                r_result <= w_prod_out;
                r_state  <= ST_DONE;
                r_done   <= 1'b1;
              end else begin
                r_state <= ST_ACC;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_ACC: begin
            r_result <= (r_op == OP_MSUB || r_op == OP_MSUBU) ? (r_hilo - w_prod_out)
                                                              : (r_hilo + w_prod_out);
            r_state  <= ST_DONE;
            r_done   <= 1'b1;
          end
          ST_DIV: begin
            if (w_core_done) begin
              r_result <= {w_rem_fix, w_quo_fix};
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign result_o      = r_result;
  assign div_by_zero_o = r_dbz;

endmodule
